// File: rtl/mod12_cmd_sched_if.sv
// ---------------------------------------------------------------------------
// mod12_cmd_sched_if
//   Command and completion bundle between the requesting control logic and
//   the mod-12 command scheduler.
//
//   req_valid  [1:0]  per-requester command valid (bit i = requester i)
//   req_ready  [1:0]  per-requester accept, at most one bit high
//   req_op     [3:0]  op for requester i at [2i+1:2i]
//                     (00 CLEAR, 01 LOAD, 10 UP, 11 DOWN)
//   req_arg    [7:0]  arg for requester i at [4i+3:4i]
//                     (load value or step count)
//   done_valid        one-cycle completion pulse, no backpressure
//   done_id           requester that issued the completed command
//   done_count [3:0]  counter value after the command
//   done_err          command rejected (LOAD value out of range)
//
//   master : requester side
//   slave  : scheduler side
// ---------------------------------------------------------------------------
interface mod12_cmd_sched_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_op;
  logic [7:0] req_arg;
  logic       done_valid;
  logic       done_id;
  logic [3:0] done_count;
  logic       done_err;

  modport master (
    output req_valid, req_op, req_arg,
    input  req_ready, done_valid, done_id, done_count, done_err
  );

  modport slave (
    input  req_valid, req_op, req_arg,
    output req_ready, done_valid, done_id, done_count, done_err
  );
endinterface

// File: rtl/mod12_cmd_sched.sv
// ---------------------------------------------------------------------------
// mod12_cmd_sched
//   Shares one mod-12 up/down counter between two requesters. Commands
//   (CLEAR, LOAD, UP n, DOWN n) arrive over valid/ready handshakes, are
//   arbitrated round-robin, and are turned into the counter's load /
//   up_down / Din controls. Between commands the counter is frozen by
//   reloading its own value. Each command ends with a one-cycle completion
//   pulse carrying the final count.
//
//   clk          clock
//   rst          synchronous active-high reset (shared with the counter)
//   bus          command/completion interface (slave modport)
//   cnt_load     to counter load
//   cnt_up_down  to counter up_down (0 = up, 1 = down)
//   cnt_din      to counter Din
//   count_in     counter's current count
//   busy         high whenever a command is in progress
// ---------------------------------------------------------------------------
module mod12_cmd_sched #(
  parameter int NREQ    = 2,
  parameter int STEP_W  = 4,
  parameter int MOD_MAX = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  mod12_cmd_sched_if.slave        bus,
  output logic                    cnt_load,
  output logic                    cnt_up_down,
  output logic [3:0]              cnt_din,
  input  logic [3:0]              count_in,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_UP    = 2'b10,
    OP_DOWN  = 2'b11
  } op_t;

  localparam logic [3:0]        MAX_CNT = 4'(MOD_MAX);
  localparam logic [STEP_W-1:0] MAX_ARG = STEP_W'(MOD_MAX);

  // Registered state
  state_t            state,      state_n;
  op_t               op_q,       op_n;
  logic [STEP_W-1:0] arg_q,      arg_n;     // load value, or steps remaining
  logic              id_q,       id_n;
  logic              rr_ptr,     rr_ptr_n;  // 1 = requester 1 favoured
  logic              dv_q,       dv_n;
  logic              did_q,      did_n;
  logic [3:0]        dcnt_q,     dcnt_n;
  logic              derr_q,     derr_n;

  // Arbitration
  logic              win_id;
  op_t               win_op;
  logic [STEP_W-1:0] win_arg;
  logic [NREQ-1:0]   ready_c;
  logic [3:0]        step_next;

  // Winner: the only valid requester, or the favoured one when both are valid.
  assign win_id  = bus.req_valid[1] & (~bus.req_valid[0] | rr_ptr);
  assign win_op  = op_t'(win_id ? bus.req_op[3:2] : bus.req_op[1:0]);
  assign win_arg = win_id ? bus.req_arg[7:4] : bus.req_arg[3:0];

  // Value the counter will hold after the current RUN cycle's step. The
  // completion count is registered, so the last step's result is predicted
  // here rather than read back one cycle late.
  always_comb begin
    step_next = count_in;
    if (op_q == OP_DOWN) begin
      step_next = (count_in == 4'd0) ? MAX_CNT : count_in - 4'd1;
    end else begin
      step_next = (count_in == MAX_CNT) ? 4'd0 : count_in + 4'd1;
    end
  end

  // Next-state and output logic.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    op_n        = op_q;
    arg_n       = arg_q;
    id_n        = id_q;
    rr_ptr_n    = rr_ptr;
    dv_n        = 1'b0;
    did_n       = did_q;
    dcnt_n      = dcnt_q;
    derr_n      = derr_q;
    ready_c     = '0;
    // Freeze the counter by reloading its own value unless told otherwise.
    cnt_load    = 1'b1;
    cnt_din     = count_in;
    cnt_up_down = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (|bus.req_valid) begin
          ready_c[win_id] = 1'b1;
          op_n     = win_op;
          id_n     = win_id;
          rr_ptr_n = ~win_id;
          unique case (win_op)
            OP_CLEAR: begin
              arg_n   = '0;
              state_n = S_LOAD;
            end
            OP_LOAD: begin
              if (win_arg > MAX_ARG) begin
                // Rejected: complete next cycle, counter untouched.
                state_n = S_DONE;
                dv_n    = 1'b1;
                did_n   = win_id;
                dcnt_n  = count_in;
                derr_n  = 1'b1;
              end else begin
                arg_n   = win_arg;
                state_n = S_LOAD;
              end
            end
            OP_UP, OP_DOWN: begin
              if (win_arg == '0) begin
                state_n = S_DONE;
                dv_n    = 1'b1;
                did_n   = win_id;
                dcnt_n  = count_in;
                derr_n  = 1'b0;
              end else begin
                arg_n   = win_arg;
                state_n = S_RUN;
              end
            end
            default: ;
          endcase
        end
      end

      S_LOAD: begin
        cnt_din = arg_q;
        state_n = S_DONE;
        dv_n    = 1'b1;
        did_n   = id_q;
        dcnt_n  = arg_q;
        derr_n  = 1'b0;
      end

      S_RUN: begin
        cnt_load    = 1'b0;
        cnt_up_down = (op_q == OP_DOWN);
        arg_n       = arg_q - STEP_W'(1);
        if (arg_q == STEP_W'(1)) begin
          state_n = S_DONE;
          dv_n    = 1'b1;
          did_n   = id_q;
          dcnt_n  = step_next;
          derr_n  = 1'b0;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_CLEAR;
      arg_q  <= '0;
      id_q   <= 1'b0;
      rr_ptr <= 1'b0;
      dv_q   <= 1'b0;
      did_q  <= 1'b0;
      dcnt_q <= 4'd0;
      derr_q <= 1'b0;
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      arg_q  <= arg_n;
      id_q   <= id_n;
      rr_ptr <= rr_ptr_n;
      dv_q   <= dv_n;
      did_q  <= did_n;
      dcnt_q <= dcnt_n;
      derr_q <= derr_n;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.done_valid = dv_q;
  assign bus.done_id    = did_q;
  assign bus.done_count = dcnt_q;
  assign bus.done_err   = derr_q;
  assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_mod12_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_mod12_cmd_sched
//   Directed bench for mod12_cmd_sched. A behavioural mod-12 up/down counter
//   stands in for the real counter instance. Inputs change after the falling
//   edge; outputs are sampled shortly after the falling edge.
// ---------------------------------------------------------------------------
module tb_mod12_cmd_sched;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_load;
  logic       cnt_up_down;
  logic [3:0] cnt_din;
  logic [3:0] count;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  mod12_cmd_sched_if bus ();

  mod12_cmd_sched dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cnt_load    (cnt_load),
    .cnt_up_down (cnt_up_down),
    .cnt_din     (cnt_din),
    .count_in    (count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared mod-12 up/down counter.
  always_ff @(posedge clk) begin
    if (rst)              count <= 4'd0;
    else if (cnt_load)    count <= cnt_din;
    else if (!cnt_up_down) count <= (count == 4'd11) ? 4'd0 : count + 4'd1;
    else                  count <= (count == 4'd0) ? 4'd11 : count - 4'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one command and wait for its completion. lat is the number of
  // cycles from the accept cycle to the done cycle, or -1 on timeout.
  task automatic send(input int id, input logic [1:0] op, input logic [3:0] arg,
                      output int lat, output logic [3:0] dcnt,
                      output logic derr, output logic did);
    bit got;
    lat  = -1;
    dcnt = 4'hx;
    derr = 1'bx;
    did  = 1'bx;
    @(negedge clk);
    bus.req_op[2*id +: 2]  = op;
    bus.req_arg[4*id +: 4] = arg;
    bus.req_valid[id]      = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      if (bus.req_ready[id]) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      bus.req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid[id] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done_valid) begin
        lat  = k;
        dcnt = bus.done_count;
        derr = bus.done_err;
        did  = bus.done_id;
        return;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({busy, bus.done_valid, bus.done_id, bus.done_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: busy/dv/id/err=%b expected 0000",
               {busy, bus.done_valid, bus.done_id, bus.done_err});
    end
    checks++;
    if (bus.done_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_done_count: got %0d expected 0", bus.done_count);
    end
    checks++;
    if ({cnt_load, cnt_up_down, cnt_din, count} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_hold: load=%b ud=%b din=%0d count=%0d expected 1 0 0 0",
               cnt_load, cnt_up_down, cnt_din, count);
    end
    checks++;
    if (bus.req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 00", bus.req_ready);
    end
  endtask

  task automatic test_load_up();
    int lat; logic [3:0] c; logic e, d;
    send(0, OP_LOAD, 4'd7, lat, c, e, d);
    checks++;
    if ({lat, c, e, d} !== {32'd2, 4'd7, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load7: lat=%0d count=%0d err=%b id=%b expected 2 7 0 0", lat, c, e, d);
    end
    // 7 + 6 steps wraps through 11 -> 0 and ends at 1.
    send(0, OP_UP, 4'd6, lat, c, e, d);
    checks++;
    if ({lat, c, e, d} !== {32'd7, 4'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL up6_wrap: lat=%0d count=%0d err=%b id=%b expected 7 1 0 0", lat, c, e, d);
    end
    checks++;
    if (count !== 4'd1) begin
      failures++;
      $display("FAIL up6_counter: got %0d expected 1", count);
    end
  endtask

  task automatic test_down();
    int lat; logic [3:0] c; logic e, d;
    // 1 -> 0 -> 11 -> 10
    send(1, OP_DOWN, 4'd3, lat, c, e, d);
    checks++;
    if ({lat, c, e, d} !== {32'd4, 4'd10, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL down3: lat=%0d count=%0d err=%b id=%b expected 4 10 0 1", lat, c, e, d);
    end
    checks++;
    if (count !== 4'd10) begin
      failures++;
      $display("FAIL down3_counter: got %0d expected 10", count);
    end
  endtask

  task automatic test_back_to_back();
    int both = 0, ng = 0, nd = 0;
    int grant [8];
    logic [3:0] dc [4];
    logic dd [4];
    do_reset();
    @(negedge clk);
    bus.req_op    = {OP_UP, OP_UP};
    bus.req_arg   = {4'd1, 4'd1};
    bus.req_valid = 2'b11;
    for (int cyc = 0; cyc < 60 && nd < 4; cyc++) begin
      #1;
      if (bus.req_ready == 2'b11) both++;
      if (bus.req_ready == 2'b01 && ng < 8) begin grant[ng] = 0; ng++; end
      if (bus.req_ready == 2'b10 && ng < 8) begin grant[ng] = 1; ng++; end
      if (bus.done_valid) begin dc[nd] = bus.done_count; dd[nd] = bus.done_id; nd++; end
      if (nd < 4) @(negedge clk);
    end
    bus.req_valid = 2'b00;
    checks++;
    if (both !== 0) begin
      failures++;
      $display("FAIL rr_one_hot: both-ready cycles=%0d expected 0", both);
    end
    checks++;
    if (nd !== 4 || ng !== 4) begin
      failures++;
      $display("FAIL rr_progress: grants=%0d dones=%0d expected 4 4", ng, nd);
    end
    for (int i = 0; i < 4 && i < ng && i < nd; i++) begin
      checks++;
      if (grant[i] !== (i % 2) || dd[i] !== 1'((i % 2)) || dc[i] !== 4'(i + 1)) begin
        failures++;
        $display("FAIL rr_%0d: grant=%0d id=%b count=%0d expected %0d %0d %0d",
                 i, grant[i], dd[i], dc[i], i % 2, i % 2, i + 1);
      end
    end
  endtask

  task automatic test_err_zero();
    int lat; logic [3:0] c; logic e, d;
    // Counter is at 4 after the round-robin test.
    send(0, OP_LOAD, 4'd13, lat, c, e, d);
    checks++;
    if ({lat, c, e, d} !== {32'd1, 4'd4, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL load13_err: lat=%0d count=%0d err=%b id=%b expected 1 4 1 0", lat, c, e, d);
    end
    checks++;
    if (count !== 4'd4) begin
      failures++;
      $display("FAIL load13_counter: got %0d expected 4", count);
    end
    send(0, OP_UP, 4'd0, lat, c, e, d);
    checks++;
    if ({lat, c, e, d} !== {32'd1, 4'd4, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL up0: lat=%0d count=%0d err=%b id=%b expected 1 4 0 0", lat, c, e, d);
    end
    send(1, OP_CLEAR, 4'd9, lat, c, e, d);
    checks++;
    if ({lat, c, e, d} !== {32'd2, 4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL clear: lat=%0d count=%0d err=%b id=%b expected 2 0 0 1", lat, c, e, d);
    end
  endtask

  task automatic test_hold();
    int lat, bad = 0; logic [3:0] c; logic e, d;
    send(1, OP_LOAD, 4'd5, lat, c, e, d);
    checks++;
    if ({lat, c} !== {32'd2, 4'd5}) begin
      failures++;
      $display("FAIL load5: lat=%0d count=%0d expected 2 5", lat, c);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (count !== 4'd5 || cnt_load !== 1'b1 || cnt_din !== 4'd5 || busy !== 1'b0 ||
          bus.done_valid !== 1'b0 || bus.done_count !== 4'd5)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL idle_hold: %0d bad cycles expected 0 (count=%0d load=%b)", bad, count, cnt_load);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    int lat; logic [3:0] c; logic e, d;
    @(negedge clk);
    bus.req_op[1:0]  = OP_UP;
    bus.req_arg[3:0] = 4'd10;
    bus.req_valid    = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL up10_accept: ready=%b expected 01", bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || count !== 4'd8) begin
      failures++;
      $display("FAIL up10_midrun: busy=%b count=%0d expected 1 8", busy, count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, bus.done_valid, count, bus.done_count} !== {1'b0, 1'b0, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL abort: busy=%b dv=%b count=%0d done_count=%0d expected 0 0 0 0",
               busy, bus.done_valid, count, bus.done_count);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done_valid || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL abort_quiet: %0d cycles with done/busy expected 0", pulses);
    end
    // Requester 0 was granted last, but reset must put the pointer back on it.
    @(negedge clk);
    bus.req_op    = {OP_UP, OP_UP};
    bus.req_arg   = {4'd1, 4'd1};
    bus.req_valid = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL abort_ptr: ready=%b expected 01", bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    send(1, OP_UP, 4'd2, lat, c, e, d);
    checks++;
    if ({lat, c, d} !== {32'd3, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL after_abort: lat=%0d count=%0d id=%b expected 3 3 1", lat, c, d);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_op    = 4'd0;
    bus.req_arg   = 8'd0;
    test_reset();
    test_load_up();
    test_down();
    test_back_to_back();
    test_err_zero();
    test_hold();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod12_cmd_sched.md
Name: mod12_cmd_sched

Overview:
Command scheduler that shares one mod-12 up/down counter between two requesters. It accepts LOAD/CLEAR/STEP-UP/STEP-DOWN commands over valid/ready handshakes, arbitrates round-robin, and sequences the counter's load/up_down/Din controls. Between commands it freezes the counter by reloading its own value. It reports completion with the final count. It sits between the requesting control logic and the counter instance.

Parameters:
NREQ, 2, number of requesters (fixed at 2; RTL need not support other values)
STEP_W, 4, width of step-count argument (max 15 steps per command)
MOD_MAX, 11, highest legal counter value

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; shared with the counter instance
req_valid  in  2  per-requester command valid; bit i = requester i
req_ready  out  2  per-requester accept; at most one bit high
req_op  in  4  op for requester i at [2i+1:2i]: 00 CLEAR, 01 LOAD, 10 UP, 11 DOWN
req_arg  in  8  arg for requester i at [4i+3:4i]: load value or step count
cnt_load  out  1  to counter load
cnt_up_down  out  1  to counter up_down (0 = up, 1 = down)
cnt_din  out  4  to counter Din
count_in  in  4  counter's current count
busy  out  1  high when state != IDLE
done_valid  out  1  one-cycle completion pulse, no backpressure
done_id  out  1  requester that issued the completed command
done_count  out  4  counter value after command
done_err  out  1  command rejected (LOAD arg > MOD_MAX)

Behaviour:
- Reset: state IDLE; busy=0, done_valid=0, done_id=0, done_count=0, done_err=0; RR pointer favours requester 0. Counter is cleared by the same rst.
- Hold: in IDLE and DONE, cnt_load=1, cnt_din=count_in, cnt_up_down=0, so the counter holds its value.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: winner = requester with valid; if both valid, the one favoured by the RR pointer. req_ready[winner]=1 combinationally, same cycle (cycle T). Accept = valid & ready. Latch op, arg, id; the pointer then favours the other requester. No other bit of req_ready is high.
- Requesters hold valid/op/arg stable until accepted. Dropping valid before accept is permitted; the request is then lost.
- CLEAR: go to LOAD with value 0.
- LOAD with arg <= 11: go to LOAD.
- LOAD with arg > 11: go to DONE with err=1; counter unchanged.
- UP/DOWN with arg = 0: go to DONE directly.
- UP/DOWN with arg > 0: go to RUN with remaining = arg.
- LOAD (T+1): cnt_load=1, cnt_din=value; next DONE.
- RUN: cnt_load=0, cnt_up_down = (op==DOWN). Decrement remaining each cycle; leave to DONE after the cycle where remaining = 1. Exactly arg counter steps occur, in cycles T+1..T+arg.
- Counter wrap is done by the counter: UP 11 -> 0, DOWN 0 -> 11.
- DONE (single cycle): done_valid=1 with done_id, done_err, and done_count=count_in (final value). Next IDLE.
- done_* are registered outputs; they are held at their last values when done_valid=0.
- Latency:
  - UP/DOWN with n>0: done at T+n+1.
  - LOAD/CLEAR: done at T+2.
  - Error or zero-step: done at T+1.
  - Next accept no earlier than the cycle after DONE.
- No acceptance in LOAD/RUN/DONE; req_ready=0 there.
- rst mid-command aborts it: no done pulse, back to IDLE, pointer reset.

Test Plan:
- Req0 LOAD 7, then Req0 UP 6 -> done_count=7 at T+2; second command wraps through 11 -> 0, done_count=1 at T+7; done_err=0.
- Req1 DOWN 3 from count 1 -> counter sequence 0, 11, 10; done_id=1, done_count=10.
- Both valid continuously with UP 1, starting after reset -> grants alternate 0,1,0,1; req_ready is never high on both bits; each done_count advances by 1.
- Req0 LOAD 13 -> done_err=1 at T+1, count unchanged. Then UP 0 -> done_valid at T+1, count unchanged, err=0.
- IDLE hold check: count 5, no requests for 20 cycles -> count stays 5, cnt_load=1 every cycle.
- rst asserted mid-RUN of UP 10 -> no done_valid, busy=0, count=0, next grant goes to req0.
